// File: rtl/vm_transition_ctrl.sv
// vm_transition_ctrl: sequences VM entry/exit state transfer, on/off command and status confirmation.
module vm_transition_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int TIMEOUT = 16,
  parameter int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_valid_i,
  input  logic [7:0]       entry_vmid_i,
  output logic             entry_ready_o,
  input  logic             exit_valid_i,
  input  logic [7:0]       exit_reason_i,
  output logic             exit_ready_o,
  output logic             vm_on_o,
  output logic [7:0]       vmid_o,
  output logic             vm_off_o,
  input  logic             running_i,
  input  logic [7:0]       current_vmid_i,
  output logic             save_o,
  output logic             load_o,
  output logic [IDX_W-1:0] xfer_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [7:0]       last_exit_reason_o
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SAVE, LOAD, ISSUE, CONFIRM, RESP} state_t;
  state_t state, state_n;
  logic op, op_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [TO_W-1:0] tcnt, tcnt_n;
  logic [7:0] vmid_r, vmid_n, reason_n;
  logic err_r, err_n;
  logic idx_last, ok;
  assign idx_last = idx == IDX_W'(NUM_REGS - 1);
  // op=1 means exit: success is virtualization dropping, otherwise the requested VMID coming up
  assign ok = op ? !running_i : (running_i && current_vmid_i == vmid_r);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= 1'b0;
      idx <= '0;
      tcnt <= '0;
      vmid_r <= '0;
      last_exit_reason_o <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_n;
      op <= op_n;
      idx <= idx_n;
      tcnt <= tcnt_n;
      vmid_r <= vmid_n;
      last_exit_reason_o <= reason_n;
      err_r <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    op_n = op;
    idx_n = idx;
    tcnt_n = tcnt;
    vmid_n = vmid_r;
    reason_n = last_exit_reason_o;
    err_n = err_r;
    case (state)
      IDLE: if (exit_valid_i) begin
        op_n = 1'b1;
        reason_n = exit_reason_i;
        err_n = !running_i;
        state_n = running_i ? SAVE : RESP;
      end else if (entry_valid_i) begin
        op_n = 1'b0;
        vmid_n = entry_vmid_i;
        err_n = running_i;
        state_n = running_i ? RESP : SAVE;
      end
      SAVE: begin
        idx_n = idx_last ? '0 : idx + 1'b1;
        state_n = idx_last ? LOAD : SAVE;
      end
      LOAD: begin
        idx_n = idx_last ? '0 : idx + 1'b1;
        state_n = idx_last ? ISSUE : LOAD;
      end
      ISSUE: begin
        tcnt_n = '0;
        state_n = CONFIRM;
      end
      CONFIRM: if (ok) begin
        err_n = 1'b0;
        state_n = RESP;
      end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
        err_n = 1'b1;
        state_n = RESP;
      end else tcnt_n = tcnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  assign exit_ready_o = state == IDLE;
  assign entry_ready_o = state == IDLE && !(exit_valid_i && entry_valid_i);
  assign vm_on_o = state == ISSUE && !op;
  assign vm_off_o = state == ISSUE && op;
  assign vmid_o = vmid_r;
  assign save_o = state == SAVE;
  assign load_o = state == LOAD;
  assign xfer_idx_o = (save_o || load_o) ? idx : '0;
  assign busy_o = state != IDLE;
  assign done_o = state == RESP;
  assign err_o = done_o && err_r;
endmodule
